// File: rtl/pkt2msg_arbiter.sv
// pkt2msg_arbiter: round-robin share of one packet-to-message stage
// among N_VC flits buffers; grant/load pulse, then hold until done.
module pkt2msg_arbiter #(
  parameter int N_VC      = 4,
  parameter int N_BITS_VC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_VC-1:0]      r_pkt_to_msg_i,
  output logic [N_VC-1:0]      g_pkt_to_msg_o,
  output logic [N_BITS_VC-1:0] msg_sel_o,
  output logic                 msg_load_o,
  input  logic                 msg_buffer_free_i,
  input  logic                 msg_done_i,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    BUSY  = 3'b100
  } state_t;

  localparam logic [N_BITS_VC-1:0] LAST = N_BITS_VC'(N_VC - 1);
  localparam logic [N_VC-1:0]      ONE  = N_VC'(1);

  state_t               state_q;
  logic [N_BITS_VC-1:0] rr_ptr_q;
  logic [N_BITS_VC-1:0] sel_q;
  logic [N_BITS_VC-1:0] pick_d;
  logic                 req_hit;

  // first request at or above rr_ptr, wrapping past N_VC-1 to 0
  always_comb begin
    pick_d = rr_ptr_q;
    for (int i = N_VC - 1; i >= 0; i--) begin
      if (r_pkt_to_msg_i[(int'(rr_ptr_q) + i) % N_VC]) begin
        pick_d = N_BITS_VC'((int'(rr_ptr_q) + i) % N_VC);
      end
    end
  end

  assign req_hit = r_pkt_to_msg_i[sel_q];

  // arbitration FSM: pick in IDLE, pulse in GRANT, wait for done in BUSY
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (msg_buffer_free_i && |r_pkt_to_msg_i) begin
            sel_q   <= pick_d;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (req_hit) begin
            rr_ptr_q <= (sel_q == LAST) ? '0
                                        : sel_q + N_BITS_VC'(1);
            state_q  <= BUSY;
          end else begin
            state_q  <= IDLE;
          end
        end
        BUSY: begin
          if (msg_done_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // a request that vanished before its grant cycle gets no grant/load
  assign g_pkt_to_msg_o = (state_q == GRANT && req_hit)
                          ? (ONE << sel_q) : '0;
  assign msg_load_o     = (state_q == GRANT) && req_hit;
  assign msg_sel_o      = sel_q;
  assign busy_o         = (state_q == GRANT) || (state_q == BUSY);

endmodule

// File: tb/tb_pkt2msg_arbiter.sv
// tb_pkt2msg_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural arbiter model.
module tb_pkt2msg_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] r;
  logic [3:0] g;
  logic [1:0] sel;
  logic       load;
  logic       free;
  logic       done;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  int m_ph  = 0;
  int m_ptr = 0;
  int m_sel = 0;

  int glog[$];

  always #5 clk = ~clk;

  pkt2msg_arbiter #(.N_VC(4), .N_BITS_VC(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .r_pkt_to_msg_i    (r),
    .g_pkt_to_msg_o    (g),
    .msg_sel_o         (sel),
    .msg_load_o        (load),
    .msg_buffer_free_i (free),
    .msg_done_i        (done),
    .busy_o            (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  function automatic int arb(input int ptr, input logic [3:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return ptr;
  endfunction

  // reference model: phase 0 idle, 1 grant cycle, 2 waiting on done
  always @(posedge clk) begin
    if (!rst) begin
      m_ph = 0; m_ptr = 0; m_sel = 0;
    end else if (m_ph == 0) begin
      if (free && r != 0) begin
        m_sel = arb(m_ptr, r);
        m_ph  = 1;
      end
    end else if (m_ph == 1) begin
      if (r[m_sel]) begin
        m_ptr = (m_sel + 1) % N;
        m_ph  = 2;
      end else begin
        m_ph = 0;
      end
    end else begin
      if (done) m_ph = 0;
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] eg;
      eg = (m_ph == 1 && r[m_sel]) ? 4'(1 << m_sel) : 4'd0;
      chk("grant", 32'(g), 32'(eg));
      chk("load", 32'(load), 32'(eg != 0));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("onehot", 32'($countones(g) <= 1), 32'd1);
      for (int i = 0; i < N; i++) if (g[i]) glog.push_back(i);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic wait_grant(input int max);
    int n = 0;
    @(negedge clk);
    while (g == 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic serve(input bit keep);
    logic [3:0] gs;
    wait_grant(30);
    gs = g;
    cyc(1);
    if (!keep) r = r & ~gs;
    pulse_done();
  endtask

  task automatic chk_log(input string tag, input int exp[$]);
    chk({tag, "_len"}, 32'(glog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(tag, 32'(glog[i]), 32'(exp[i]));
  endtask

  initial begin
    rst = 1'b0; r = '0; free = 1'b0; done = 1'b0;
    // 1 reset with random inputs
    @(posedge clk); #1;
    chk_en = 1;
    r = 4'($urandom); free = 1'b1; done = 1'($urandom);
    cyc(1);
    chk("rst_g", 32'(g), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);
    r = '0; done = 1'b0; rst = 1'b1;
    cyc(3);
    chk("idle_busy", 32'(busy), 0);

    // 3 rotation with all VCs requesting
    glog.delete();
    r = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        wait_grant(30);
        cyc(1);
        r = '0;
        pulse_done();
      end else begin
        serve(1'b1);
      end
    end
    chk_log("rot", '{0, 1, 2, 3, 0});

    // 2 single request on VC2 with exact timing
    cyc(2);
    r = 4'b0100;
    cyc(1);
    @(negedge clk);
    chk("sgl_g", 32'(g), 32'h4);
    chk("sgl_load", 32'(load), 1);
    chk("sgl_sel", 32'(sel), 2);
    cyc(1);
    r = '0;
    cyc(3);
    done = 1'b1;
    @(negedge clk);
    chk("sgl_busy_d", 32'(busy), 1);
    cyc(1);
    done = 1'b0;
    @(negedge clk);
    chk("sgl_idle", 32'(busy), 0);

    // 4 wrap and skip from rr_ptr=3
    cyc(1);
    glog.delete();
    r = 4'b0011;
    serve(1'b0);
    serve(1'b0);
    chk_log("wrap", '{0, 1});

    // 5 backpressure
    cyc(2);
    r = 4'b0001; free = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_nogrant", 32'(g), 0);
      cyc(1);
    end
    free = 1'b1;
    @(negedge clk);
    chk("bp_c6", 32'(g), 0);
    cyc(1);
    @(negedge clk);
    chk("bp_c7", 32'(g), 32'h1);
    cyc(1);
    r = '0;
    pulse_done();

    // 6 reset in BUSY
    cyc(2);
    r = 4'b0010;
    wait_grant(30);
    chk("rb_g", 32'(g), 32'h2);
    cyc(1);
    r = '0;
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_busy", 32'(busy), 0);
    cyc(1);
    r = 4'b0011;
    wait_grant(30);
    chk("rb_vc0", 32'(g), 32'h1);
    cyc(1);
    r = '0;
    pulse_done();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r    = 4'($urandom);
      free = ($urandom_range(3) != 0);
      done = ($urandom_range(3) == 0);
      rst  = ($urandom_range(63) != 0);
      cyc(1);
    end
    rst = 1'b1; r = '0; done = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
